store_port_responder: RTL and testbench



---
 rtl/store_port_responder.sv | 158 +++++++++++++++
 tb/tb_store_port_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_port_responder.sv
// Memory-side responder for the store_buffer dcache request port: delayed/stalled
// grants, byte-enabled word array for stores, tagged load lookup with rvalid pulse.
module store_port_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [76:0]      req_port_i,
  output logic [34:0]      req_port_o,
  input  logic [3:0]       gnt_delay_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] store_count_o,
  output logic             busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, TAG} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [11:0] index_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic [31:0] mem_q [DEPTH];

  logic [11:0] req_index;
  logic [21:0] req_tag;
  logic [31:0] req_wdata;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_be;
  logic        req_kill;
  logic        req_tag_valid;
  logic [33:0] gnt_addr;
  logic [33:0] tag_addr;
  logic [AW-1:0] gnt_word;
  logic [AW-1:0] tag_word;
  logic        gnt_c;
  logic        unused_bits;

  assign req_index     = req_port_i[76:65];
  assign req_tag       = req_port_i[64:43];
  assign req_wdata     = req_port_i[42:11];
  assign req_valid     = req_port_i[9];
  assign req_we        = req_port_i[8];
  assign req_be        = req_port_i[7:4];
  assign req_kill      = req_port_i[1];
  assign req_tag_valid = req_port_i[0];

  // Grant-cycle word comes from the live request; the TAG lookup pairs the live
  // tag with the index latched at grant.
  assign gnt_addr = {req_tag, req_index};
  assign tag_addr = {req_tag, index_q};
  assign gnt_word = gnt_addr[AW+1:2];
  assign tag_word = tag_addr[AW+1:2];

  assign unused_bits = ^{gnt_addr[33:AW+2], gnt_addr[1:0], tag_addr[33:AW+2],
                         tag_addr[1:0], req_port_i[10], req_port_i[3:2]};

  // Grant decode: combinational from state, request and stall.
  always_comb begin
    gnt_c = 1'b0;
    if (!rst_i && req_valid && !stall_i) begin
      case (state_q)
        IDLE:    gnt_c = (gnt_delay_i == 4'd0);
        WAIT:    gnt_c = (cnt_q <= 4'd1);
        default: gnt_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      index_q       <= 12'd0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'd0;
      store_count_o <= '0;
      busy_q        <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (gnt_c) begin
        if (req_we) begin
          store_count_o <= store_count_o + CNT_W'(1);
          state_q       <= IDLE;
          busy_q        <= 1'b0;
        end else begin
          index_q <= req_index;
          state_q <= TAG;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid && gnt_delay_i != 4'd0) begin
              cnt_q   <= gnt_delay_i;
              state_q <= WAIT;
              busy_q  <= 1'b1;
            end
          end
          WAIT: begin
            if (!req_valid) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          TAG: begin
            if (req_kill) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (req_tag_valid) begin
              rdata_q  <= mem_q[tag_word];
              rvalid_q <= 1'b1;
              state_q  <= IDLE;
              busy_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Backing array: byte-enabled write on a store grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= 32'd0;
      end
    end else if (gnt_c && req_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) begin
          mem_q[gnt_word][8*k +: 8] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Reset blanks the response in the same cycle.
  always_comb begin
    req_port_o = '0;
    if (!rst_i) begin
      req_port_o = {gnt_c, rvalid_q, rdata_q, 1'b0};
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_store_port_responder.sv
// Directed bench for store_port_responder: grants, delays, stall, partial writes,
// loads, kill, aliasing and mid-operation reset.
module tb_store_port_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [76:0] req;
  logic [34:0] rsp;
  logic [3:0]  dly;
  logic        stall;
  logic [15:0] count;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_port_responder #(.DEPTH(64), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_port_i(req), .req_port_o(rsp),
    .gnt_delay_i(dly), .stall_i(stall), .store_count_o(count), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [76:0] mk(input logic [33:0] addr, input logic [31:0] wd,
                                     input logic rq, input logic we, input logic [3:0] be,
                                     input logic kill, input logic tv);
    return {addr[11:0], addr[33:12], wd, 1'b0, rq, we, be, 2'b10, kill, tv};
  endfunction

  // Same-cycle store grant with gnt_delay 0; leaves the request driven.
  task automatic store0(input string tag, input logic [33:0] addr, input logic [31:0] wd,
                        input logic [3:0] be);
    dly = 4'd0;
    req = mk(addr, wd, 1'b1, 1'b1, be, 1'b0, 1'b0);
    #1 chk({tag, "_gnt"}, 64'(rsp[34]), 64'd1);
    @(negedge clk);
  endtask

  // Load: grant, tag_valid in TAG, then check the rvalid pulse and data.
  task automatic load0(input string tag, input logic [33:0] addr, input logic [31:0] exp);
    dly = 4'd0;
    req = mk(addr, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    #1 chk({tag, "_gnt"}, 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = mk(addr, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    #1 chk({tag, "_tag_nognt"}, 64'(rsp[34]), 64'd0);
    chk({tag, "_tag_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    req = '0;
    #1 chk({tag, "_rvalid"}, 64'(rsp[33]), 64'd1);
    chk({tag, "_rdata"}, 64'(rsp[32:1]), 64'(exp));
    @(negedge clk);
    #1 chk({tag, "_rvalid_pulse"}, 64'(rsp[33]), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; dly = 4'd0; stall = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 chk("reset_rsp", 64'(rsp), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle store then readback of word 4
    store0("st1", 34'h10, 32'hDEADBEEF, 4'hF);
    req = '0;
    #1 chk("st1_count", 64'(count), 64'd1);
    chk("st1_idle_busy", 64'(busy), 64'd0);
    chk("st1_ruser", 64'(rsp[0]), 64'd0);
    @(negedge clk);
    load0("ld1", 34'h10, 32'hDEADBEEF);

    // gnt_delay 3: grant exactly in the third cycle after the request
    dly = 4'd3;
    req = mk(34'h20, 32'h12345678, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    #1 chk("d3_c0_gnt", 64'(rsp[34]), 64'd0);
    @(negedge clk);
    #1 chk("d3_c1_gnt", 64'(rsp[34]), 64'd0);
    chk("d3_c1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    #1 chk("d3_c2_gnt", 64'(rsp[34]), 64'd0);
    @(negedge clk);
    #1 chk("d3_c3_gnt", 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = '0;
    #1 chk("d3_gnt_off", 64'(rsp[34]), 64'd0);
    chk("d3_count", 64'(count), 64'd2);
    @(negedge clk);
    load0("ld_d3", 34'h20, 32'h12345678);

    // Partial write then load in the very next cycle (read-after-write)
    store0("st_part", 34'h10, 32'h11223344, 4'b0101);
    load0("ld_part", 34'h10, 32'hDE22BE44);
    store0("st_be0", 34'h10, 32'hFFFFFFFF, 4'b0000);
    req = '0;
    #1 chk("be0_count", 64'(count), 64'd4);
    @(negedge clk);
    load0("ld_be0", 34'h10, 32'hDE22BE44);

    // Stall in IDLE with delay 0, then stall through WAIT
    stall = 1'b1; dly = 4'd0;
    req = mk(34'h30, 32'hA5A5A5A5, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    #1 chk("stall_idle_gnt", 64'(rsp[34]), 64'd0);
    @(negedge clk);
    #1 chk("stall_idle_busy", 64'(busy), 64'd0);
    dly = 4'd2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_wait_gnt", 64'(rsp[34]), 64'd0);
      chk("stall_wait_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    stall = 1'b0;
    #1 chk("stall_release_gnt", 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = '0;
    #1 chk("stall_count", 64'(count), 64'd5);
    chk("stall_busy_after", 64'(busy), 64'd0);
    @(negedge clk);

    // Load killed in TAG, then a normal store is granted
    dly = 4'd0;
    req = mk(34'h30, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    #1 chk("kill_ld_gnt", 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = mk(34'h30, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    #1 chk("kill_tag_gnt", 64'(rsp[34]), 64'd0);
    @(negedge clk);
    req = mk(34'h40, 32'hCAFEF00D, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    #1 chk("kill_no_rvalid", 64'(rsp[33]), 64'd0);
    chk("kill_idle_busy", 64'(busy), 64'd0);
    chk("kill_next_gnt", 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = '0;
    #1 chk("kill_count", 64'(count), 64'd6);
    @(negedge clk);
    load0("ld_w12", 34'h30, 32'hA5A5A5A5);

    // rvalid coinciding with a same-cycle store grant
    req = mk(34'h40, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    #1 chk("co_ld_gnt", 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = mk(34'h40, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    req = mk(34'h80, 32'h01020304, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    #1 chk("co_rvalid", 64'(rsp[33]), 64'd1);
    chk("co_rdata", 64'(rsp[32:1]), 64'hCAFEF00D);
    chk("co_gnt", 64'(rsp[34]), 64'd1);
    @(negedge clk);
    req = '0;
    #1 chk("co_count", 64'(count), 64'd7);
    @(negedge clk);
    load0("ld_alias", 34'h140, 32'hCAFEF00D);
    load0("ld_w32", 34'h80, 32'h01020304);

    // Request dropped in WAIT: no grant, no count
    dly = 4'd4;
    req = mk(34'h10, 32'h0BADF00D, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("drop_wait_busy", 64'(busy), 64'd1);
    @(negedge clk);
    req = '0;
    #1 chk("drop_gnt", 64'(rsp[34]), 64'd0);
    @(negedge clk);
    #1 chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_count", 64'(count), 64'd7);
    @(negedge clk);

    // Reset while in WAIT with counter 2
    dly = 4'd3;
    req = mk(34'h10, 32'h0BADF00D, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_rsp", 64'(rsp), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #1 chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_gnt", 64'(rsp[34]), 64'd0);
    @(negedge clk);
    load0("ld_rst_w4", 34'h10, 32'd0);
    load0("ld_rst_w16", 34'h40, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
